// File: rtl/clk_freq_monitor_pkg.sv
// Shared types and width helpers for the PLL clock frequency monitor.
package clk_freq_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clk_freq_monitor_edge_sync.sv
// Three-flop synchronizer for an asynchronous clock treated as data,
// followed by a rising-edge detector on the settled stages.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_o
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_o = s2 & ~s3;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of a PLL output over a fixed reference-clock gate
// window and reports the count, an in-range flag and a debounced lock.
//
// state  | meaning
// IDLE   | counters held at zero, waiting for enable_i
// GATE   | counting meas_clk_i edges for GATE_CYCLES reference cycles
// REPORT | one cycle: publish count, update range flag and lock logic
module clk_freq_monitor
  import clk_freq_monitor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = 1000,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned EXP_MIN      = 248,
  parameter int unsigned EXP_MAX      = 252,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             meas_clk_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             count_valid_o,
  output logic             in_range_o,
  output logic             locked_o,
  output logic             lock_lost_o
);

  localparam int unsigned GATE_W = cnt_width(GATE_CYCLES - 1);
  localparam int unsigned RUN_W  = cnt_width(LOCK_WINDOWS);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  LIM_MIN   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  LIM_MAX   = CNT_W'(EXP_MAX);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_WINDOWS);

  state_t            state_q;
  state_t            state_d;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [RUN_W-1:0]  run_q;
  logic              meas_edge;

  logic              gate_en;
  logic              gate_last;
  logic              report;
  logic              abort;
  logic              in_range_now;
  logic [RUN_W-1:0]  run_inc;
  logic              lost_set;

  edge_sync u_edge_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (meas_clk_i),
    .edge_o (meas_edge)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    gate_en   = 1'b0;
    gate_last = 1'b0;
    report    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (!enable_i) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gate_en = 1'b1;
          if (gate_cnt_q == GATE_LAST) begin
            gate_last = 1'b1;
            state_d   = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        report  = 1'b1;
        state_d = enable_i ? ST_GATE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The final gate cycle still accumulates its edge; everything outside
  // an active gate (IDLE, REPORT, abort) clears both counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else if (gate_en) begin
      gate_cnt_q <= gate_last ? '0 : gate_cnt_q + 1'b1;
      if (edge_cnt_q != CNT_MAX)
        edge_cnt_q <= edge_cnt_q + CNT_W'(meas_edge);
    end else begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
    end
  end

  always_comb begin
    in_range_now = (edge_cnt_q >= LIM_MIN) && (edge_cnt_q <= LIM_MAX);
    run_inc      = (run_q == RUN_FULL) ? run_q : run_q + 1'b1;
    lost_set     = report && !in_range_now && locked_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o       <= '0;
      count_valid_o <= 1'b0;
      in_range_o    <= 1'b0;
      locked_o      <= 1'b0;
      run_q         <= '0;
    end else begin
      count_valid_o <= report;
      if (report) begin
        count_o    <= edge_cnt_q;
        in_range_o <= in_range_now;
        if (in_range_now) begin
          run_q <= run_inc;
          if (run_inc == RUN_FULL) locked_o <= 1'b1;
        end else begin
          run_q    <= '0;
          locked_o <= 1'b0;
        end
      end else if (abort) begin
        // Aborted window: published results hold, but the run restarts.
        run_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         lock_lost_o <= 1'b0;
    else if (lost_set) lock_lost_o <= 1'b1;
    else if (clear_i)  lock_lost_o <= 1'b0;
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: 100 MHz reference, 25/30 MHz measured
// clock, lock/abort/clear/reset scenarios plus a saturating CNT_W=4 instance.
`timescale 1ns/1ps
module tb_clk_freq_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        meas_clk = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] count;
  logic        count_valid;
  logic        in_range;
  logic        locked;
  logic        lock_lost;

  logic [3:0]  sat_count;
  logic        sat_valid;
  logic        sat_in_range;
  logic        sat_locked;
  logic        sat_lock_lost;

  int n_checks = 0;
  int n_fail   = 0;
  real meas_half = 20.0;

  clk_freq_monitor dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .meas_clk_i    (meas_clk),
    .enable_i      (enable),
    .clear_i       (clear),
    .count_o       (count),
    .count_valid_o (count_valid),
    .in_range_o    (in_range),
    .locked_o      (locked),
    .lock_lost_o   (lock_lost)
  );

  clk_freq_monitor #(.CNT_W(4)) dut_sat (
    .clk_i         (clk),
    .rst_i         (rst),
    .meas_clk_i    (meas_clk),
    .enable_i      (enable),
    .clear_i       (clear),
    .count_o       (sat_count),
    .count_valid_o (sat_valid),
    .in_range_o    (sat_in_range),
    .locked_o      (sat_locked),
    .lock_lost_o   (sat_lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #3;
    forever #(meas_half) meas_clk = ~meas_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (count_valid) seen = 1'b1;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  function automatic logic in_win(input logic [15:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  initial begin
    int cyc;
    int pulses;

    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_valid", count_valid, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_lost", lock_lost, 0);

    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;

    // One IDLE->GATE edge, 1000 gate edges, then the REPORT edge registers the pulse.
    wait_valid(1100, cyc);
    chk("first_latency", cyc, 1002);
    chk("w1_count_25m", in_win(count, 249, 251), 1);
    chk("w1_in_range", in_range, 1);
    chk("w1_locked", locked, 0);
    chk("sat_count", sat_count, 15);
    chk("sat_valid", sat_valid, 1);
    chk("sat_in_range", sat_in_range, 0);

    for (int w = 2; w <= 4; w++) begin
      wait_valid(1100, cyc);
      chk("period", cyc, 1001);
      chk("count_25m", in_win(count, 249, 251), 1);
      chk("lock_progress", locked, (w == 4));
    end

    meas_half = 16.667;
    wait_valid(1100, cyc);
    chk("w5_in_range", in_range, 0);
    chk("w5_locked", locked, 0);
    chk("w5_lock_lost", lock_lost, 1);

    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    chk("clear_lock_lost", lock_lost, 0);

    wait_valid(1100, cyc);
    chk("w6_count_30m", in_win(count, 299, 301), 1);
    chk("w6_in_range", in_range, 0);

    meas_half = 20.0;
    wait_valid(1100, cyc);
    wait_valid(1100, cyc);
    chk("w8_in_range", in_range, 1);

    repeat (500) @(negedge clk);
    enable = 1'b0;
    pulses = 0;
    repeat (1500) begin
      @(negedge clk);
      if (count_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_in_range_hold", in_range, 1);
    chk("abort_locked_hold", locked, 0);
    chk("abort_count_hold", in_win(count, 249, 251), 1);

    enable = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_valid(1100, cyc);
      if (w == 1) chk("reenable_latency", cyc, 1002);
      chk("fresh_lock", locked, (w == 4));
    end

    // Land clear_i on the REPORT cycle of a lock-losing window.
    meas_half = 16.667;
    repeat (1000) @(negedge clk);
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    chk("setwin_valid", count_valid, 1);
    chk("setwin_lock_lost", lock_lost, 1);
    chk("setwin_locked", locked, 0);
    chk("setwin_in_range", in_range, 0);

    repeat (300) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", count_valid, 0);
    chk("arst_in_range", in_range, 0);
    chk("arst_locked", locked, 0);
    chk("arst_lock_lost", lock_lost, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_valid(1100, cyc);
    chk("arst_latency", cyc, 1002);
    chk("arst_count_30m", in_win(count, 299, 301), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
